// File: rtl/btn_debouncer.sv
// Purpose : per-channel synchronizer + stability-counter debouncer for board buttons/switches,
//           producing a clean level, one-cycle press/release pulses and a press-toggled latch.
// Latency : a clean input step reaches btn_db after SYNC_STAGES + DEBOUNCE_CYCLES rising edges.
// Flow    : no backpressure; free-running, one decision per channel per clock.
//
// Ports:
//   clk            system clock
//   rst            synchronous reset, active-high
//   btn_raw        raw asynchronous button/switch levels, active-high
//   btn_db         debounced levels (feeds SoC gpio_in)
//   press_pulse    one-cycle pulse in the cycle btn_db[i] rises
//   release_pulse  one-cycle pulse in the cycle btn_db[i] falls
//   toggle         inverts on every press_pulse[i]
module btn_debouncer #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] btn_raw,
  output logic [WIDTH-1:0] btn_db,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse,
  output logic [WIDTH-1:0] toggle
);

  // Counter only needs to reach DEBOUNCE_CYCLES-1, which always fits in clog2 bits.
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    ST_STABLE  = 1'b0,  // sync agrees with btn_db, counter idle at 0
    ST_PENDING = 1'b1   // sync disagrees, counting consecutive disagreeing cycles
  } state_t;

  // Reject unusable configurations at elaboration time.
  if (WIDTH < 1 || SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2) begin : g_bad_params
    $fatal(1, "btn_debouncer: WIDTH>=1, SYNC_STAGES>=2 and DEBOUNCE_CYCLES>=2 are required");
  end

  // ---------------------------------------------------------------------------
  // Input synchronizer: btn_raw is asynchronous, so it only ever enters the
  // design through this flop chain; nothing downstream sees btn_raw directly.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= btn_raw;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Per-channel debounce FSM. Every channel has its own state, counter and
  // output flops, so simultaneous events are handled on independent timelines.
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    state_t        state_q, state_nxt;
    logic [CW-1:0] cnt_q,   cnt_nxt;
    logic          db_q,    db_nxt;
    logic          press_q, press_nxt;
    logic          rel_q,   rel_nxt;
    logic          tog_q,   tog_nxt;

    always_ff @(posedge clk) begin
      if (rst) begin
        // Any pending count is dropped; a still-held input starts over as a new press.
        state_q <= ST_STABLE;
        cnt_q   <= '0;
        db_q    <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        tog_q   <= 1'b0;
      end else begin
        state_q <= state_nxt;
        cnt_q   <= cnt_nxt;
        db_q    <= db_nxt;
        press_q <= press_nxt;
        rel_q   <= rel_nxt;
        tog_q   <= tog_nxt;
      end
    end

    always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      db_nxt    = db_q;
      press_nxt = 1'b0;
      rel_nxt   = 1'b0;
      tog_nxt   = tog_q;

      case (state_q)
        ST_STABLE: begin
          // The first disagreeing cycle counts as 1.
          if (sync[i] != db_q) begin
            cnt_nxt   = CW'(1);
            state_nxt = ST_PENDING;
          end
        end

        ST_PENDING: begin
          if (sync[i] == db_q) begin
            // Bounce: throw the partial count away, outputs untouched.
            cnt_nxt   = '0;
            state_nxt = ST_STABLE;
          end else if (cnt_q == CNT_LAST) begin
            // DEBOUNCE_CYCLES consecutive disagreeing cycles: accept the new level.
            // The counter is cleared here, so it can never wrap.
            db_nxt    = sync[i];
            cnt_nxt   = '0;
            state_nxt = ST_STABLE;
            press_nxt = sync[i];
            rel_nxt   = ~sync[i];
            if (sync[i]) begin
              tog_nxt = ~tog_q;
            end
          end else begin
            cnt_nxt = cnt_q + CW'(1);
          end
        end

        default: begin
          state_nxt = ST_STABLE;
          cnt_nxt   = '0;
        end
      endcase
    end

    assign btn_db[i]        = db_q;
    assign press_pulse[i]   = press_q;
    assign release_pulse[i] = rel_q;
    assign toggle[i]        = tog_q;

    // A channel only ever takes one edge at a time.
    assert property (@(posedge clk) !(press_q && rel_q));
  end

endmodule

// File: tb/tb_btn_debouncer.sv
// Self-checking bench for btn_debouncer with DEBOUNCE_CYCLES shortened to 8.
// The reference model tracks, per channel, the synchronized sample stream and the
// length of the current run of samples that disagree with the debounced level.
module tb_btn_debouncer;

  localparam int W  = 4;
  localparam int SS = 2;
  localparam int DB = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] btn_raw;
  logic [W-1:0] btn_db;
  logic [W-1:0] press_pulse;
  logic [W-1:0] release_pulse;
  logic [W-1:0] toggle;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  btn_debouncer #(
    .WIDTH          (W),
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_raw      (btn_raw),
    .btn_db       (btn_db),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .toggle       (toggle)
  );

  // ---------------- reference model ----------------
  bit [W-1:0] m_pipe [SS];   // raw samples in flight to the synchronized value
  int         m_run  [W];    // consecutive synchronized samples disagreeing with m_db
  bit [W-1:0] m_db, m_press, m_rel, m_tog;

  task automatic model_edge();
    bit [W-1:0] s;
    if (rst) begin
      for (int k = 0; k < SS; k++) m_pipe[k] = '0;
      for (int c = 0; c < W; c++) m_run[c] = 0;
      m_db = '0; m_press = '0; m_rel = '0; m_tog = '0;
    end else begin
      s       = m_pipe[SS-1];
      m_press = '0;
      m_rel   = '0;
      for (int c = 0; c < W; c++) begin
        if (s[c] != m_db[c]) begin
          m_run[c] = m_run[c] + 1;
          if (m_run[c] == DB) begin
            m_db[c]  = s[c];
            m_run[c] = 0;
            if (s[c]) begin
              m_press[c] = 1'b1;
              m_tog[c]   = ~m_tog[c];
            end else begin
              m_rel[c] = 1'b1;
            end
          end
        end else begin
          m_run[c] = 0;
        end
      end
      for (int k = SS-1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
      m_pipe[0] = btn_raw;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One rising edge, model update, then compare all outputs 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("btn_db",        btn_db,        m_db);
    chk("press_pulse",   press_pulse,   m_press);
    chk("release_pulse", release_pulse, m_rel);
    chk("toggle",        toggle,        m_tog);
    chk("press_and_release", press_pulse & release_pulse, 0);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    run(n);
    rst = 1'b0;
  endtask

  initial begin
    int saw;
    int hold [W];
    logic [W-1:0] lvl;

    rst     = 1'b1;
    btn_raw = '0;

    // ---- 1. reset state and clean press/release ----
    run(3);
    chk("rst_btn_db", btn_db, 0);
    chk("rst_press", press_pulse, 0);
    chk("rst_release", release_pulse, 0);
    chk("rst_toggle", toggle, 0);
    rst     = 1'b0;
    btn_raw = 4'b0001;
    run(9);
    chk("t1_db_edge9", btn_db[0], 0);
    step();
    chk("t1_db_edge10", btn_db[0], 1);
    chk("t1_press", press_pulse, 4'b0001);
    chk("t1_toggle", toggle[0], 1);
    step();
    chk("t1_press_one_cycle", press_pulse, 0);
    btn_raw = 4'b0000;
    run(9);
    chk("t1_rel_edge9", release_pulse, 0);
    step();
    chk("t1_release", release_pulse, 4'b0001);
    chk("t1_db_low", btn_db[0], 0);
    chk("t1_toggle_held", toggle[0], 1);
    step();
    chk("t1_release_one_cycle", release_pulse, 0);

    // ---- 2. bounce rejection ----
    do_reset(1);
    for (int c = 0; c < 40; c++) begin
      btn_raw[1] = ((c / 3) % 2 == 0);
      step();
      chk("t2_db_bounce", btn_db[1], 0);
      chk("t2_no_pulse", press_pulse | release_pulse, 0);
    end
    btn_raw[1] = 1'b1;
    run(9);
    chk("t2_db_edge9", btn_db[1], 0);
    step();
    chk("t2_db_edge10", btn_db[1], 1);
    chk("t2_press", press_pulse, 4'b0010);

    // ---- 3. threshold: an N-sample pulse is accepted iff N >= DEBOUNCE_CYCLES ----
    btn_raw = '0;
    do_reset(1);
    for (int w = DB - 1; w <= DB + 1; w++) begin
      saw = 0;
      btn_raw[2] = 1'b1;
      for (int k = 0; k < w; k++) begin
        step();
        if (press_pulse[2]) saw++;
      end
      btn_raw[2] = 1'b0;
      for (int k = 0; k < 30; k++) begin
        step();
        if (press_pulse[2]) saw++;
      end
      if (w == DB - 1) chk("t3_short_rejected", saw, 0);
      if (w == DB + 1) chk("t3_long_accepted", saw, 1);
    end

    // ---- 4. simultaneous channels ----
    do_reset(1);
    btn_raw = 4'b1111;
    run(9);
    step();
    chk("t4_press_all", press_pulse, 4'b1111);
    chk("t4_toggle_all", toggle, 4'b1111);
    btn_raw = 4'b0000; run(12);
    btn_raw = 4'b1111; run(12);
    btn_raw = 4'b0000; run(12);
    chk("t4_toggle_back", toggle, 4'b0000);

    // ---- 5. reset mid-debounce ----
    do_reset(1);
    btn_raw = 4'b1000;
    run(5);
    rst = 1'b1;
    step();
    chk("t5_rst_db", btn_db, 0);
    chk("t5_rst_pulses", press_pulse | release_pulse, 0);
    chk("t5_rst_toggle", toggle, 0);
    rst = 1'b0;
    run(9);
    chk("t5_db_edge9", btn_db[3], 0);
    step();
    chk("t5_db_edge10", btn_db[3], 1);
    chk("t5_press", press_pulse[3], 1);

    // ---- 6. long hold: exactly one press, no spurious events ----
    btn_raw = '0;
    do_reset(1);
    btn_raw = 4'b0001;
    saw = 0;
    for (int k = 0; k < 1000; k++) begin
      step();
      if (press_pulse[0] || release_pulse[0]) saw++;
    end
    chk("t6_one_event", saw, 1);
    chk("t6_db_held", btn_db[0], 1);

    // ---- 7. random independent bouncing on all channels ----
    btn_raw = '0;
    do_reset(1);
    lvl = '0;
    for (int c = 0; c < W; c++) hold[c] = 0;
    for (int k = 0; k < 2000; k++) begin
      for (int c = 0; c < W; c++) begin
        if (hold[c] == 0) begin
          lvl[c]  = ~lvl[c];
          hold[c] = $urandom_range(1, 14);
        end
        hold[c] = hold[c] - 1;
      end
      btn_raw = lvl;
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
